// File: rtl/mux_n_to_1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_n_to_1
//  Purpose  : Registered, parameterised N-to-1 single-bit multiplexer.
//             Picks I[S] through a balanced binary mux tree and registers it
//             on Y one clock after an en strobe. Out-of-range selects
//             (S >= N, only possible when N is not a power of two) yield 0.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N        number of data inputs, legal range 2..256 (default 8)
//    SW       select width, derived as $clog2(N) (not overridable)
//  Ports
//    clk      in   1   rising-edge clock
//    rst_n    in   1   asynchronous active-low reset
//    I        in   N   data inputs, I[k] is input k
//    S        in   SW  binary select
//    en       in   1   capture strobe, sample I[S] this cycle
//    clr_err  in   1   synchronous clear of sel_err
//    Y        out  1   registered selected bit
//    Y_valid  out  1   one-cycle pulse following each en capture
//    sel_err  out  1   sticky out-of-range select flag
//  Configuration
//    MUX_N_TO_1_SEL_CHECK_EN  defined: range comparator and sticky sel_err
//                             present. Undefined: sel_err tied 0 and
//                             clr_err ignored.
// ============================================================================
module mux_n_to_1 #(
   parameter int N = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           I,
   input  logic [$clog2(N)-1:0]   S,
   input  logic                   en,
   input  logic                   clr_err,
   output logic                   Y,
   output logic                   Y_valid,
   output logic                   sel_err
);

   localparam int SW         = $clog2(N);
   // Leaf count of the full tree; leaves at or above N are zero-filled.
   localparam int c_leaves   = 1 << SW;

   // Heap-ordered tree: node 1 is the root, node j has children 2j and 2j+1,
   // leaves live at indices c_leaves .. 2*c_leaves-1 (leaf k = input k).
   logic [2*c_leaves-1:1] w_node;
   logic                  w_sel;

   logic                  r_y;
   logic                  r_y_valid;

   // -------------------------------------------------------------------------
   // Leaf layer
   // -------------------------------------------------------------------------
   for (genvar k = 0; k < c_leaves; k++) begin : g_leaf
      if (k < N) begin : g_real
         assign w_node[c_leaves+k] = I[k];
      end else begin : g_pad
         // Unused leaves read as 0, giving the out-of-range result for free.
         assign w_node[c_leaves+k] = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Internal nodes. A node at depth d steers on select bit SW-1-d, so the
   // root decodes the MSB and the bottom level decodes the LSB.
   // -------------------------------------------------------------------------
   for (genvar j = 1; j < c_leaves; j++) begin : g_node
      localparam int c_depth = $clog2(j + 1) - 1;
      assign w_node[j] = S[SW-1-c_depth] ? w_node[2*j+1] : w_node[2*j];
   end

   assign w_sel = w_node[1];

   // -------------------------------------------------------------------------
   // Output capture
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y       <= 1'b0;
         r_y_valid <= 1'b0;
      end else begin
         if (en) begin
            r_y <= w_sel;
         end
         r_y_valid <= en;
      end
   end

   assign Y       = r_y;
   assign Y_valid = r_y_valid;

   // -------------------------------------------------------------------------
   // Select-range checking
   // -------------------------------------------------------------------------
`ifdef MUX_N_TO_1_SEL_CHECK_EN
   // One bit wider than S so that N itself (e.g. 256 with SW=8) is representable.
   localparam logic [SW:0] c_n_limit = (SW+1)'(N);

   logic w_out_of_range;
   logic r_sel_err;

   assign w_out_of_range = ({1'b0, S} >= c_n_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_err <= 1'b0;
      end else if (en && w_out_of_range) begin
         // Setting takes priority over a simultaneous clear.
         r_sel_err <= 1'b1;
      end else if (clr_err) begin
         r_sel_err <= 1'b0;
      end
   end

   assign sel_err = r_sel_err;
`else
   logic w_unused_clr_err;

   assign w_unused_clr_err = clr_err;
   assign sel_err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_n_to_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_n_to_1
//  Purpose  : Self-checking bench for mux_n_to_1. Instantiates an N=8 and an
//             N=6 copy, drives directed scenarios plus random traffic, and
//             compares every output against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_n_to_1;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] i8;
   logic [2:0] s8;
   logic       en8, clr8;
   logic       y8, yv8, err8;

   logic [5:0] i6;
   logic [2:0] s6;
   logic       en6, clr6;
   logic       y6, yv6, err6;

   int         total = 0;
   int         bad   = 0;

   // Reference model state
   logic       m8_y, m8_v, m8_err;
   logic       m6_y, m6_v, m6_err;

`ifdef MUX_N_TO_1_SEL_CHECK_EN
   localparam bit c_check = 1'b1;
`else
   localparam bit c_check = 1'b0;
`endif

   always #5 clk = ~clk;

   mux_n_to_1 #(.N(8)) u_dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .I       (i8),
      .S       (s8),
      .en      (en8),
      .clr_err (clr8),
      .Y       (y8),
      .Y_valid (yv8),
      .sel_err (err8)
   );

   mux_n_to_1 #(.N(6)) u_dut6 (
      .clk     (clk),
      .rst_n   (rst_n),
      .I       (i6),
      .S       (s6),
      .en      (en6),
      .clr_err (clr6),
      .Y       (y6),
      .Y_valid (yv6),
      .sel_err (err6)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".y8"},    y8,   m8_y);
      check({tag, ".v8"},    yv8,  m8_v);
      check({tag, ".err8"},  err8, m8_err);
      check({tag, ".y6"},    y6,   m6_y);
      check({tag, ".v6"},    yv6,  m6_v);
      check({tag, ".err6"},  err6, m6_err);
   endtask

   task automatic model_reset();
      m8_y = 1'b0; m8_v = 1'b0; m8_err = 1'b0;
      m6_y = 1'b0; m6_v = 1'b0; m6_err = 1'b0;
   endtask

   // Behavioural model: selected bit is (I >> S) & 1 when S < N, else 0.
   task automatic model_edge();
      int unsigned b8, b6;
      b8 = (int'(s8) < 8) ? ((int'(i8) >> s8) & 1) : 0;
      b6 = (int'(s6) < 6) ? ((int'(i6) >> s6) & 1) : 0;
      if (en8) m8_y = (b8 != 0);
      m8_v = en8;
      if (en6) m6_y = (b6 != 0);
      m6_v = en6;
      if (c_check && en6 && int'(s6) >= 6) m6_err = 1'b1;
      else if (c_check && clr6)            m6_err = 1'b0;
   endtask

   // Advance one clock, update the model from the inputs that were present at
   // the edge, then check shortly afterwards.
   task automatic step(input string tag);
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      i8 = '0; s8 = '0; en8 = 1'b0; clr8 = 1'b0;
      i6 = '0; s6 = '0; en6 = 1'b0; clr6 = 1'b0;
      model_reset();

      // Reset state
      #2;
      check_all("reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_all("post_reset");

      // N=8: I=1010_1101, S stepped 0..7 back-to-back
      i8  = 8'b1010_1101;
      en8 = 1'b1;
      for (int s = 0; s < 8; s++) begin
         s8 = 3'(s);
         step("walk8");
      end

      // Capture S=3 (=1), then idle while S and I move: Y holds
      s8 = 3'd3;
      step("cap3");
      check("cap3_is_1", y8, 1'b1);
      en8 = 1'b0; s8 = 3'd1; i8 = 8'h00;
      step("hold8");
      check("hold8_y", y8, 1'b1);
      check("hold8_v", yv8, 1'b0);

      // N=6: out-of-range select, sticky flag, clear
      i6 = 6'b111111; en6 = 1'b1; s6 = 3'd6;
      step("oor6");
      check("oor6_y0", y6, 1'b0);
      s6 = 3'd2;
      step("inr6");
      check("inr6_y1", y6, 1'b1);
      en6 = 1'b0; clr6 = 1'b1;
      step("clr6");
      check("clr6_err0", err6, 1'b0);

      // Set and clear in the same cycle: set wins
      en6 = 1'b1; s6 = 3'd7; clr6 = 1'b1;
      step("setwins6");
      check("setwins6_err", err6, c_check);
      clr6 = 1'b0;

      // Mid-stream asynchronous reset with Y=1
      i8 = 8'hFF; s8 = 3'd0; en8 = 1'b1;
      step("pre_rst");
      check("pre_rst_y1", y8, 1'b1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      step("in_rst");
      #1;
      rst_n = 1'b1;
      en8 = 1'b0; en6 = 1'b0;
      step("rst_idle");
      en8 = 1'b1; en6 = 1'b1; s6 = 3'd1;
      step("rst_first");

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         i8   = 8'($urandom);
         s8   = 3'($urandom);
         en8  = ($urandom_range(0, 3) != 0);
         clr8 = ($urandom_range(0, 7) == 0);
         i6   = 6'($urandom);
         s6   = 3'($urandom);
         en6  = ($urandom_range(0, 3) != 0);
         clr6 = ($urandom_range(0, 7) == 0);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
